// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the datapath memory stage and the data-memory bus.
// Turns one core load/store into a single word-aligned bus transaction with a
// req/ack handshake, builds byte enables and replicated store data, and
// extracts and sign/zero-extends load data. Flags misaligned accesses, illegal
// funct3 and bus timeout.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_req, i_we       core request (held while o_stall=1), 1=store 0=load
//   i_f3              funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
//   i_addr, i_wdata   byte address, store data
//   o_stall           hold core pipeline
//   o_done            one-cycle completion pulse
//   o_rdata           extended load data (valid with o_done)
//   o_fault           access faulted (valid with o_done)
//   o_fault_code      01 misaligned, 10 illegal funct3, 11 timeout
//   o_mem_*           registered bus request, write, word address, data, byte enables
//   i_mem_ack         bus accept / read data valid
//   i_mem_rdata       bus read word
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_f3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic [1:0]  o_fault_code,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StErr
    } state_e;

    state_e      state_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt_q;
    logic        done_q;
    logic        fault_q;
    logic [1:0]  code_q;
    logic [31:0] rdata_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;

    // Request decode, evaluated on the incoming core request.
    logic        legal;
    logic        aligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    always_comb begin
        legal    = 1'b0;
        aligned  = 1'b1;
        st_be    = 4'b0000;
        st_wdata = 32'h0;
        case (i_f3)
            3'b000: begin
                legal    = 1'b1;
                st_be    = 4'b0001 << i_addr[1:0];
                st_wdata = {4{i_wdata[7:0]}};
            end
            3'b001: begin
                legal    = 1'b1;
                aligned  = ~i_addr[0];
                st_be    = 4'b0011 << i_addr[1:0];
                st_wdata = {2{i_wdata[15:0]}};
            end
            3'b010: begin
                legal    = 1'b1;
                aligned  = (i_addr[1:0] == 2'b00);
                st_be    = 4'b1111;
                st_wdata = i_wdata;
            end
            3'b100: begin
                legal = ~i_we;
            end
            3'b101: begin
                legal   = ~i_we;
                aligned = ~i_addr[0];
            end
            default: legal = 1'b0;
        endcase
    end

    // Load extraction from the bus word using the latched funct3 and byte offset.
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;

    always_comb begin
        ld_shift = i_mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            cnt_q       <= 8'h0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= 2'b00;
            rdata_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'b0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_req) begin
                        f3_q  <= i_f3;
                        off_q <= i_addr[1:0];
                        if (!legal) begin
                            // Illegal funct3 wins over misalignment.
                            state_q <= StErr;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                            code_q  <= 2'b10;
                            rdata_q <= 32'h0;
                        end else if (!aligned) begin
                            state_q <= StErr;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                            code_q  <= 2'b01;
                            rdata_q <= 32'h0;
                        end else begin
                            state_q     <= StReq;
                            cnt_q       <= 8'h0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= i_we;
                            mem_addr_q  <= {i_addr[31:2], 2'b00};
                            mem_wdata_q <= i_we ? st_wdata : 32'h0;
                            mem_be_q    <= i_we ? st_be : 4'b1111;
                        end
                    end
                end
                StReq: begin
                    if (i_mem_ack || (cnt_q == TimeoutLast)) begin
                        state_q     <= StResp;
                        done_q      <= 1'b1;
                        fault_q     <= ~i_mem_ack;
                        code_q      <= i_mem_ack ? 2'b00 : 2'b11;
                        rdata_q     <= (i_mem_ack && !mem_we_q) ? ld_ext : 32'h0;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_wdata_q <= 32'h0;
                        mem_be_q    <= 4'b0000;
                    end else begin
                        cnt_q <= cnt_q + 8'h1;
                    end
                end
                StResp, StErr: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    code_q  <= 2'b00;
                    rdata_q <= 32'h0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_stall      = ((state_q == StIdle) && i_req) || (state_q == StReq);
    assign o_done       = done_q;
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;
    assign o_rdata      = rdata_q;
    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_mem_be     = mem_be_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: transaction-level model of the load/store rules and
// timing, a per-cycle compare process, and literal expectations for the
// directed vectors.
module tb_lsu_mem_ctrl;

    localparam int T = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic        i_we;
    logic [2:0]  i_f3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_fault;
    logic [1:0]  o_fault_code;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_f3         (i_f3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_fault      (o_fault),
        .o_fault_code (o_fault_code),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_be     (o_mem_be),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int sz(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] model_code(input logic we, input logic [2:0] f3,
                                              input logic [31:0] addr);
        bit legal;
        legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ||
                (!we && (f3 == 3'b100 || f3 == 3'b101));
        if (!legal) return 2'b10;
        if ((int'(addr[1:0]) % sz(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int m;
        m = ((1 << sz(f3)) - 1) << int'(addr[1:0]);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        longint v;
        if (sz(f3) == 1) v = longint'(d[7:0]) * 64'h01010101;
        else if (sz(f3) == 2) v = longint'(d[15:0]) * 64'h00010001;
        else v = longint'(d);
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        longint v;
        longint mask;
        int bits;
        bits = 8 * sz(f3);
        v = longint'(word) >> (8 * int'(addr[1:0]));
        mask = (64'sd1 <<< bits) - 1;
        v = v & mask;
        if ((f3 == 3'b000 || f3 == 3'b001) && (((v >> (bits - 1)) & 1) == 1))
            v = v - (64'sd1 <<< bits);
        return 32'(v);
    endfunction

    // ---------------- compare process ----------------
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_done, exp_mreq, exp_mwe, exp_chk_wdata;
    logic        exp_fault, exp_chk_rdata;
    logic [1:0]  exp_code;
    logic [31:0] exp_maddr, exp_mwdata, exp_rdata;
    logic [3:0]  exp_be;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(o_stall), 32'(exp_stall));
            chk("done", 32'(o_done), 32'(exp_done));
            chk("mem_req", 32'(o_mem_req), 32'(exp_mreq));
            if (exp_mreq) begin
                chk("mem_we", 32'(o_mem_we), 32'(exp_mwe));
                chk("mem_addr", o_mem_addr, exp_maddr);
                chk("mem_be", 32'(o_mem_be), 32'(exp_be));
                if (exp_chk_wdata) chk("mem_wdata", o_mem_wdata, exp_mwdata);
            end
            if (exp_done) begin
                chk("fault", 32'(o_fault), 32'(exp_fault));
                chk("fault_code", 32'(o_fault_code), 32'(exp_code));
                if (exp_chk_rdata) chk("rdata", o_rdata, exp_rdata);
            end
        end
    end

    // Captured DUT observations for the literal checks.
    int          cap_stall, cap_done_at, cap_req_cycles;
    logic [31:0] cap_rdata, cap_maddr, cap_mwdata;
    logic [1:0]  cap_code;
    logic [3:0]  cap_be;
    logic        cap_mwe;

    // Entered at posedge+1; ack_at = REQ cycle (1-based) carrying the ack, 0 = never.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word,
                           input int ack_at);
        logic [1:0] code;
        int n;
        int total;
        bit in_req;
        bit is_done;
        code  = model_code(we, f3, addr);
        n     = (ack_at > 0) ? ack_at : T;
        total = (code != 2'b00) ? 2 : n + 2;
        cap_stall = 0; cap_done_at = -1; cap_req_cycles = 0;
        cap_rdata = 32'h0; cap_code = 2'b00; cap_maddr = 32'h0; cap_mwdata = 32'h0;
        cap_be = 4'h0; cap_mwe = 1'b0;
        i_we = we; i_f3 = f3; i_addr = addr; i_wdata = wdata; i_mem_rdata = word;
        chk_en = 1'b1;
        for (int c = 0; c <= total; c++) begin
            in_req  = (code == 2'b00) && (c >= 1) && (c <= n);
            is_done = (c == total - 1);
            i_req     = (c < total - 1);
            i_mem_ack = in_req && (c == ack_at);
            exp_stall = (c == 0) || in_req;
            exp_done  = is_done;
            exp_mreq  = in_req;
            exp_mwe   = we;
            exp_maddr = {addr[31:2], 2'b00};
            exp_be    = we ? model_be(f3, addr) : 4'b1111;
            exp_mwdata    = model_wdata(f3, wdata);
            exp_chk_wdata = we;
            exp_fault = (code != 2'b00) || (ack_at == 0);
            exp_code  = (code != 2'b00) ? code : ((ack_at == 0) ? 2'b11 : 2'b00);
            exp_chk_rdata = !we || exp_fault;
            exp_rdata = exp_fault ? 32'h0 : model_load(f3, addr, word);
            @(negedge clk);
            if (o_stall) cap_stall++;
            if (o_mem_req) begin
                cap_req_cycles++;
                cap_maddr = o_mem_addr; cap_mwdata = o_mem_wdata;
                cap_be = o_mem_be; cap_mwe = o_mem_we;
            end
            if (o_done) begin
                cap_done_at = c; cap_rdata = o_rdata; cap_code = o_fault_code;
            end
            @(posedge clk);
            #1;
        end
        i_mem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_f3 = 3'b000; i_addr = 32'h0;
        i_wdata = 32'h0; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
        #12;
        chk("rst_stall", 32'(o_stall), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_mem_req", 32'(o_mem_req), 32'h0);
        chk("rst_fault", 32'(o_fault), 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SW, ack on third REQ cycle.
        run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3);
        chk("sw_stall_cycles", 32'(cap_stall), 32'd4);
        chk("sw_done_cycle", 32'(cap_done_at), 32'd4);
        chk("sw_addr", cap_maddr, 32'h100);
        chk("sw_be", 32'(cap_be), 32'hF);
        chk("sw_wdata", cap_mwdata, 32'hDEADBEEF);

        // SB at byte 3.
        run_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
        chk("sb_addr", cap_maddr, 32'h100);
        chk("sb_wdata", cap_mwdata, 32'hA5A5A5A5);
        chk("sb_be", 32'(cap_be), 32'h8);
        chk("sb_we", 32'(cap_mwe), 32'h1);
        chk("sb_done_cycle", 32'(cap_done_at), 32'd2);

        // SH at halfword 1.
        run_txn(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 2);
        chk("sh_wdata", cap_mwdata, 32'hABCDABCD);
        chk("sh_be", 32'(cap_be), 32'hC);

        // Loads at 0x102 from 0x12F45678.
        run_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h12F45678, 1);
        chk("lb_rdata", cap_rdata, 32'hFFFFFFF4);
        chk("lb_be", 32'(cap_be), 32'hF);
        run_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h12F45678, 1);
        chk("lbu_rdata", cap_rdata, 32'h000000F4);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h12F45678, 2);
        chk("lh_rdata", cap_rdata, 32'h000012F4);
        run_txn(1'b0, 3'b001, 32'h100, 32'h0, 32'h00008001, 1);
        chk("lh_neg_rdata", cap_rdata, 32'hFFFF8001);
        run_txn(1'b0, 3'b101, 32'h100, 32'h0, 32'h00008001, 1);
        chk("lhu_rdata", cap_rdata, 32'h00008001);

        // Faults.
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1);
        chk("lw_mis_code", 32'(cap_code), 32'h1);
        chk("lw_mis_done_cycle", 32'(cap_done_at), 32'd1);
        chk("lw_mis_no_req", 32'(cap_req_cycles), 32'd0);
        run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1);
        chk("f3_011_code", 32'(cap_code), 32'h2);
        run_txn(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1);
        chk("sbu_code", 32'(cap_code), 32'h2);
        run_txn(1'b0, 3'b111, 32'h101, 32'h0, 32'h0, 1);
        chk("illegal_over_mis", 32'(cap_code), 32'h2);

        // Timeout.
        run_txn(1'b0, 3'b010, 32'h0, 32'h0, 32'h55555555, 0);
        chk("to_req_cycles", 32'(cap_req_cycles), 32'd4);
        chk("to_code", 32'(cap_code), 32'h3);
        chk("to_rdata", cap_rdata, 32'h0);
        chk("to_done_cycle", 32'(cap_done_at), 32'd5);

        // Reset in the middle of REQ.
        chk_en = 1'b0;
        i_we = 1'b1; i_f3 = 3'b010; i_addr = 32'h200; i_wdata = 32'h11223344;
        i_mem_rdata = 32'hCAFEF00D; i_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_req_active", 32'(o_mem_req), 32'h1);
        rst_n = 1'b0; i_req = 1'b0;
        #1;
        chk("abort_mem_req", 32'(o_mem_req), 32'h0);
        chk("abort_mem_we", 32'(o_mem_we), 32'h0);
        chk("abort_mem_addr", o_mem_addr, 32'h0);
        chk("abort_mem_be", 32'(o_mem_be), 32'h0);
        chk("abort_mem_wdata", o_mem_wdata, 32'h0);
        chk("abort_stall", 32'(o_stall), 32'h0);
        chk("abort_done", 32'(o_done), 32'h0);
        @(posedge clk); #1;
        i_mem_ack = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_ack_done", 32'(o_done), 32'h0);
            chk("late_ack_req", 32'(o_mem_req), 32'h0);
            @(posedge clk); #1;
            i_mem_ack = 1'b0;
        end
        run_txn(1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 1);
        chk("post_rst_rdata", cap_rdata, 32'hCAFEF00D);
        chk("post_rst_done_cycle", 32'(cap_done_at), 32'd2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
